instr_loader: RTL

- Byte-serial program loader. Receives a big-endian byte stream, assembles 32-bit MIPS instruction words and writes them into word-addressed instruction memory before the CPU runs.
- Acts as the producing end of the instruction stream that the CPU control decoder consumes.
- Screens each word against the decoder's supported opcode/func set, so the CPU never fetches an instruction it cannot decode.

---
 rtl/instr_loader.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// instr_loader: byte-serial program loader for MIPS instruction memory.
// Assembles big-endian bytes into 32-bit words and writes each legal word
// to consecutive word addresses starting at BASE_ADDR. A word of all ones
// ends the session.
// Optional feature macro: ILLEGAL_CHECK_EN. When it is defined, words outside
// the decoder's opcode/func set are rejected. When it is undefined, every
// non-marker word is written and err_illegal is tied low.
module instr_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_full,
    output logic              err_illegal,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LP_LAST = '1;
    localparam logic [31:0]       LP_MARK = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [23:0]         r_word;        // bytes already received for this word
    logic [1:0]          r_byte_cnt;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_full;        // last slot has been written
    logic [ADDR_W:0]     r_word_count;
    logic                r_err_full;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [31:0]         r_imem_wdata;

    logic [31:0]         w_word;
    logic                w_accept;
    logic                w_last_byte;
    logic                w_marker;
    logic                w_illegal;
    logic                w_start_session;
    logic                w_go_write;
    logic                w_set_err_full;
    logic                w_set_err_illegal;

`ifdef ILLEGAL_CHECK_EN
    logic                r_err_illegal;

    // Opcode/func set the CPU control decoder understands.
    function automatic logic f_is_legal(input logic [31:0] word);
        logic [5:0] op;
        logic [5:0] fn;
        op = word[31:26];
        fn = word[5:0];
        case (op)
            6'd0:    f_is_legal = (fn == 6'd32) || (fn == 6'd34) ||
                                  (fn == 6'd42) || (fn == 6'd8);
            6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd10, 6'd35, 6'd43:
                     f_is_legal = 1'b1;
            default: f_is_legal = 1'b0;
        endcase
    endfunction

    assign w_illegal = !f_is_legal(w_word);
`else
    assign w_illegal = 1'b0;
`endif

    // Word as it stands once the current byte is appended.
    assign w_word      = {r_word, byte_in};
    // A byte presented alongside start is dropped with the old session.
    assign w_accept    = (r_state == S_LOAD) && byte_valid && !start;
    assign w_last_byte = w_accept && (r_byte_cnt == 2'd3);
    assign w_marker    = (w_word == LP_MARK);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        w_state_next      = r_state;
        w_start_session   = 1'b0;
        w_go_write        = 1'b0;
        w_set_err_full    = 1'b0;
        w_set_err_illegal = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next    = S_LOAD;
                    w_start_session = 1'b1;
                end
            end
            S_LOAD: begin
                if (start) begin
                    w_state_next    = S_LOAD;
                    w_start_session = 1'b1;
                end else if (w_last_byte) begin
                    if (w_marker) begin
                        w_state_next = S_DONE;
                    end else if (w_illegal) begin
                        w_set_err_illegal = 1'b1;
                    end else if (r_full) begin
                        w_set_err_full = 1'b1;
                        w_state_next   = S_DONE;
                    end else begin
                        w_go_write   = 1'b1;
                        w_state_next = S_WRITE;
                    end
                end
            end
            // start is ignored here so the pending write always lands.
            S_WRITE: begin
                w_state_next = S_LOAD;
            end
            S_DONE: begin
                if (start) begin
                    w_state_next    = S_LOAD;
                    w_start_session = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Word assembly, write pointer, counters and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word       <= '0;
            r_byte_cnt   <= '0;
            r_ptr        <= LP_BASE;
            r_full       <= 1'b0;
            r_word_count <= '0;
            r_err_full   <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else if (w_start_session) begin
            r_word       <= '0;
            r_byte_cnt   <= '0;
            r_ptr        <= LP_BASE;
            r_full       <= 1'b0;
            r_word_count <= '0;
            r_err_full   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_word     <= w_word[23:0];
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (w_go_write) begin
                r_imem_addr  <= r_ptr;
                r_imem_wdata <= w_word;
            end
            if (w_set_err_full) begin
                r_err_full <= 1'b1;
            end
            // Pointer saturates at the last slot; the full flag blocks the next word.
            if (r_state == S_WRITE) begin
                r_word_count <= r_word_count + 1'b1;
                if (r_ptr == LP_LAST) begin
                    r_full <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
        end
    end

`ifdef ILLEGAL_CHECK_EN
    // Sticky flag for rejected words, cleared only by a new session.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_illegal <= 1'b0;
        end else if (w_start_session) begin
            r_err_illegal <= 1'b0;
        end else if (w_set_err_illegal) begin
            r_err_illegal <= 1'b1;
        end
    end

    assign err_illegal = r_err_illegal;
`else
    assign err_illegal = 1'b0;
`endif

    assign byte_ready = (r_state == S_LOAD);
    assign imem_we    = (r_state == S_WRITE);
    assign busy       = (r_state == S_LOAD) || (r_state == S_WRITE);
    assign done       = (r_state == S_DONE);
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign err_full   = r_err_full;
    assign word_count = r_word_count;

endmodule
